mdio_responder: RTL

MDIO_RESPONDER -- requirements
Module: mdio_responder

---
 rtl/mdio_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mdio_responder.sv
// Clause-22 MDIO management responder with a 32x16 register file.
// MDC is oversampled in the clk domain; data is sampled on MDC rise and driven on MDC fall.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] ID1      = 16'h0141,
    parameter logic [15:0] ID2      = 16'h0CC2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        rd_done
);

    typedef enum logic [2:0] {IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA} state_t;

    state_t      state;
    logic        mdc_q;
    logic [5:0]  pre_cnt;
    logic [4:0]  bit_cnt;
    logic        op_hi;
    logic        is_read;
    logic        phy_match;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] shreg;
    logic [15:0] regs [32];
    logic [15:0] rd_val;
    logic [15:0] wdata_full;
    logic        rise;
    logic        fall;

    assign rise       = ~mdc_q & mdc;
    assign fall       = mdc_q & ~mdc;
    assign wdata_full = {shreg[14:0], mdio_in};

    // Registers 2 and 3 are the read-only identifier words.
    always_comb begin
        rd_val = regs[regad];
        if (regad == 5'd2)      rd_val = ID1;
        else if (regad == 5'd3) rd_val = ID2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mdc_q     <= 1'b0;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            op_hi     <= 1'b0;
            is_read   <= 1'b0;
            phy_match <= 1'b0;
            phy       <= '0;
            regad     <= '0;
            shreg     <= '0;
            mdio_out  <= 1'b0;
            mdio_oe   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_done   <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            mdc_q   <= mdc;
            wr_en   <= 1'b0;
            rd_done <= 1'b0;
            if (rise) begin
                case (state)
                    IDLE: begin
                        if (mdio_in) begin
                            if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
                        end else begin
                            pre_cnt <= '0;
                            if (pre_cnt == 6'd32) state <= START;
                        end
                    end
                    START: begin
                        bit_cnt <= '0;
                        state   <= mdio_in ? OP : IDLE;
                    end
                    OP: begin
                        if (bit_cnt == 5'd0) begin
                            op_hi   <= mdio_in;
                            bit_cnt <= 5'd1;
                        end else begin
                            bit_cnt <= '0;
                            is_read <= op_hi;
                            state   <= (op_hi ^ mdio_in) ? PHYAD : IDLE;
                        end
                    end
                    PHYAD: begin
                        phy <= {phy[3:0], mdio_in};
                        if (bit_cnt == 5'd4) begin
                            phy_match <= ({phy[3:0], mdio_in} == PHY_ADDR);
                            bit_cnt   <= '0;
                            state     <= REGAD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    REGAD: begin
                        regad <= {regad[3:0], mdio_in};
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            state   <= phy_match ? TA : IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    TA: begin
                        // Write turnaround is clocked by rises; read turnaround by falls.
                        if (!is_read) begin
                            if (bit_cnt == 5'd1) begin
                                bit_cnt <= '0;
                                state   <= WDATA;
                            end else begin
                                bit_cnt <= 5'd1;
                            end
                        end
                    end
                    WDATA: begin
                        shreg <= wdata_full;
                        if (bit_cnt == 5'd15) begin
                            if (regad != 5'd2 && regad != 5'd3) begin
                                regs[regad] <= wdata_full;
                                wr_en       <= 1'b1;
                                wr_addr     <= regad;
                                wr_data     <= wdata_full;
                            end
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (fall) begin
                case (state)
                    TA: begin
                        if (is_read) begin
                            if (bit_cnt == 5'd0) begin
                                bit_cnt <= 5'd1;
                            end else begin
                                mdio_oe  <= 1'b1;
                                mdio_out <= 1'b0;
                                shreg    <= rd_val;
                                bit_cnt  <= '0;
                                state    <= RDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (bit_cnt == 5'd16) begin
                            mdio_oe  <= 1'b0;
                            mdio_out <= 1'b0;
                            rd_done  <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= IDLE;
                        end else begin
                            mdio_out <= shreg[15];
                            shreg    <= {shreg[14:0], 1'b0};
                            bit_cnt  <= bit_cnt + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
